// File: rtl/pcq_pm_thold_seq_if.sv
// Bundle of the sleep-request, quiesce, configuration, block and PM output
// signals exchanged between the thold sequencer and its environment.
interface pcq_pm_thold_seq_if #(
    parameter int unsigned THREADS = 2,
    parameter int unsigned DLY_W   = 4
);
    logic [THREADS-1:0] pm_sleep_req;
    logic [THREADS-1:0] thrd_quiesced;
    logic [DLY_W-1:0]   cfg_enter_dly;
    logic [DLY_W-1:0]   cfg_exit_dly;
    logic               rg_ck_fast_xstop;
    logic               lbist_en_dc;
    logic               ct_ck_pm_ccflush_disable;
    logic               ct_ck_pm_raise_tholds;
    logic               pm_sleep_active;
    logic               pm_wake_done;
    logic [2:0]         pm_state;

    // Environment side: drives requests/config, observes PM controls
    modport master (
        output pm_sleep_req, thrd_quiesced, cfg_enter_dly, cfg_exit_dly,
               rg_ck_fast_xstop, lbist_en_dc,
        input  ct_ck_pm_ccflush_disable, ct_ck_pm_raise_tholds,
               pm_sleep_active, pm_wake_done, pm_state
    );

    // Sequencer side
    modport slave (
        input  pm_sleep_req, thrd_quiesced, cfg_enter_dly, cfg_exit_dly,
               rg_ck_fast_xstop, lbist_en_dc,
        output ct_ck_pm_ccflush_disable, ct_ck_pm_raise_tholds,
               pm_sleep_active, pm_wake_done, pm_state
    );
endinterface

// File: rtl/pcq_pm_thold_seq.sv
// Power-management thold sequencer: on a full sleep request and thread
// quiesce it disables ccflush, waits a settle delay, then raises tholds.
// Wake undoes the steps in reverse order with its own settle delay.
// Fast checkstop or LBIST blocks entry and aborts/forces wake.
module pcq_pm_thold_seq #(
    parameter int unsigned THREADS = 2,
    parameter int unsigned DLY_W   = 4
) (
    input logic                 clk,
    input logic                 rst,
    pcq_pm_thold_seq_if.slave   pm_if
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_QWAIT    = 3'd1,
        ST_FLUSHDIS = 3'd2,
        ST_SLEEP    = 3'd3,
        ST_LOWER    = 3'd4,
        ST_FLUSHEN  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;

    logic all_req;
    logic all_quiesced;
    logic blk;
    logic leave_req;

    logic flushdis;
    logic raise;
    logic sleep_act;
    logic wake_done;

    assign all_req      = &pm_if.pm_sleep_req;
    assign all_quiesced = &pm_if.thrd_quiesced;
    assign blk          = pm_if.rg_ck_fast_xstop | pm_if.lbist_en_dc;
    assign leave_req    = ~all_req | blk;

    // State and settle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter load/decrement
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (all_req && !blk) state_d = ST_QWAIT;
            end
            ST_QWAIT: begin
                // Abort is checked before quiesce so a simultaneous drop wins
                if (leave_req) begin
                    state_d = ST_RUN;
                end else if (all_quiesced) begin
                    state_d = ST_FLUSHDIS;
                    cnt_d   = pm_if.cfg_enter_dly;
                end
            end
            ST_FLUSHDIS: begin
                if (leave_req) begin
                    state_d = ST_RUN;
                end else if (cnt_q == '0) begin
                    state_d = ST_SLEEP;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            ST_SLEEP: begin
                if (leave_req) begin
                    state_d = ST_LOWER;
                    cnt_d   = pm_if.cfg_exit_dly;
                end
            end
            ST_LOWER: begin
                // Wake is committed here; inputs are deliberately ignored
                if (cnt_q == '0) begin
                    state_d = ST_FLUSHEN;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            ST_FLUSHEN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        flushdis  = 1'b0;
        raise     = 1'b0;
        sleep_act = 1'b0;
        wake_done = 1'b0;
        case (state_q)
            ST_FLUSHDIS: flushdis = 1'b1;
            ST_SLEEP: begin
                flushdis  = 1'b1;
                raise     = 1'b1;
                sleep_act = 1'b1;
            end
            ST_LOWER:    flushdis  = 1'b1;
            ST_FLUSHEN:  wake_done = 1'b1;
            default: ;
        endcase
    end

    assign pm_if.ct_ck_pm_ccflush_disable = flushdis;
    assign pm_if.ct_ck_pm_raise_tholds    = raise;
    assign pm_if.pm_sleep_active          = sleep_act;
    assign pm_if.pm_wake_done             = wake_done;
    assign pm_if.pm_state                 = state_q;

endmodule

// File: tb/tb_pcq_pm_thold_seq.sv
// Directed-vector bench for the PM thold sequencer with a scoreboard queue:
// the stimulus process pushes the expected state/outputs for a cycle and an
// independent monitor pops and compares on the falling edge.
module tb_pcq_pm_thold_seq;

    localparam int unsigned THREADS = 2;
    localparam int unsigned DLY_W   = 4;

    localparam logic [2:0] S_RUN = 3'd0, S_QW = 3'd1, S_FD = 3'd2,
                           S_SL = 3'd3, S_LO = 3'd4, S_FE = 3'd5;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [3:0] outs;   // {ccflush_disable, raise_tholds, sleep_active, wake_done}
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sbq[$];

    pcq_pm_thold_seq_if #(.THREADS(THREADS), .DLY_W(DLY_W)) pif ();

    pcq_pm_thold_seq #(.THREADS(THREADS), .DLY_W(DLY_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .pm_if (pif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand table of outputs per state
    function automatic logic [3:0] outs_of(input logic [2:0] st);
        case (st)
            S_FD:    return 4'b1000;
            S_SL:    return 4'b1110;
            S_LO:    return 4'b1000;
            S_FE:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input logic [2:0] st);
        exp_t e;
        e.cyc  = cyc;
        e.st   = st;
        e.outs = outs_of(st);
        e.nm   = nm;
        sbq.push_back(e);
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        logic [3:0] act;
        exp_t e;
        act = {pif.ct_ck_pm_ccflush_disable, pif.ct_ck_pm_raise_tholds,
               pif.pm_sleep_active, pif.pm_wake_done};
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_vec++;
            if (e.cyc != cyc) begin
                n_miss++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.nm, e.cyc, cyc);
            end else if (pif.pm_state !== e.st || act !== e.outs) begin
                n_miss++;
                $display("FAIL %s @cyc %0d: state=%0d outs=%b, expected state=%0d outs=%b",
                         e.nm, cyc, pif.pm_state, act, e.st, e.outs);
            end
        end
    end

    initial begin
        pif.pm_sleep_req     = '0;
        pif.thrd_quiesced    = '0;
        pif.cfg_enter_dly    = 4'd3;
        pif.cfg_exit_dly     = 4'd2;
        pif.rg_ck_fast_xstop = 1'b0;
        pif.lbist_en_dc      = 1'b0;

        // Reset and idle
        rst = 1'b1;
        tick(); tick();
        expect_st("reset", S_RUN);
        rst = 1'b0;
        tick(); expect_st("idle", S_RUN);

        // Entry with enter delay 3; cfg changed mid-delay must not matter
        pif.pm_sleep_req = 2'b11;
        tick(); expect_st("enter_qwait", S_QW);
        pif.thrd_quiesced = 2'b11;
        tick(); expect_st("flushdis_c2", S_FD);
        pif.cfg_enter_dly = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_st("flushdis_hold", S_FD);
        end
        tick(); expect_st("sleep_c6", S_SL);
        tick(); expect_st("sleep_hold", S_SL);

        // Wake by dropping req[1]; exit delay 2; cfg changed mid-delay
        pif.pm_sleep_req = 2'b01;
        tick(); expect_st("lower_raise_fall", S_LO);
        pif.cfg_exit_dly = 4'd7;
        tick(); expect_st("lower_hold1", S_LO);
        tick(); expect_st("lower_hold2", S_LO);
        tick(); expect_st("flushen_pulse", S_FE);
        tick(); expect_st("run_after_wake", S_RUN);
        tick(); expect_st("run_req_low", S_RUN);

        // Delay-0 entry, then reset mid-SLEEP
        pif.cfg_enter_dly = 4'd0;
        pif.pm_sleep_req  = 2'b11;
        tick(); expect_st("d0_qwait", S_QW);
        tick(); expect_st("d0_flushdis_1cyc", S_FD);
        tick(); expect_st("d0_sleep", S_SL);
        rst = 1'b1;
        pif.pm_sleep_req = 2'b00;
        tick(); expect_st("rst_mid_sleep", S_RUN);
        rst = 1'b0;
        tick(); expect_st("after_rst", S_RUN);

        // Abort from FLUSHDIS with cnt=5 via LBIST
        pif.cfg_enter_dly = 4'd5;
        pif.thrd_quiesced = 2'b00;
        pif.pm_sleep_req  = 2'b11;
        tick(); expect_st("ab_qwait", S_QW);
        tick(); expect_st("ab_qwait_unbounded", S_QW);
        pif.thrd_quiesced = 2'b11;
        tick(); expect_st("ab_flushdis", S_FD);
        pif.lbist_en_dc = 1'b1;
        tick(); expect_st("lbist_abort", S_RUN);
        tick(); expect_st("lbist_blocks_entry", S_RUN);
        pif.lbist_en_dc   = 1'b0;
        pif.thrd_quiesced = 2'b00;
        tick(); expect_st("qw_again", S_QW);
        // Request drop coincident with quiesce: abort wins
        pif.pm_sleep_req  = 2'b10;
        pif.thrd_quiesced = 2'b11;
        tick(); expect_st("qw_drop_vs_quiesce", S_RUN);

        // Fast checkstop in SLEEP with requests held; both delays 0
        pif.cfg_enter_dly = 4'd0;
        pif.cfg_exit_dly  = 4'd0;
        pif.pm_sleep_req  = 2'b11;
        tick(); expect_st("xs_qwait", S_QW);
        tick(); expect_st("xs_flushdis", S_FD);
        tick(); expect_st("xs_sleep", S_SL);
        pif.rg_ck_fast_xstop = 1'b1;
        tick(); expect_st("xs_lower_1cyc", S_LO);
        tick(); expect_st("xs_flushen", S_FE);
        tick(); expect_st("xs_run", S_RUN);
        tick(); expect_st("xs_hold_run1", S_RUN);
        tick(); expect_st("xs_hold_run2", S_RUN);
        pif.rg_ck_fast_xstop = 1'b0;
        tick(); expect_st("xs_release_qwait", S_QW);
        pif.pm_sleep_req = 2'b00;
        tick(); expect_st("final_run", S_RUN);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pcq_pm_thold_seq.md
# pcq_pm_thold_seq

Power-management thold sequencer in the PCQ clock-control area. It collects per-thread sleep requests and waits for the threads to quiesce. It then drives the clock-control PM inputs in a fixed order: flush-disable first, then raise tholds. On wake it undoes them in reverse order, with programmable settle delays, and it aborts or wakes on fast checkstop or LBIST.

## Interface
Parameters:
- THREADS, 2, number of hardware threads issuing sleep requests
- DLY_W, 4, width of the enter/exit settle-delay fields

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- pm_sleep_req  in  THREADS  per-thread level sleep request; sleep entry needs all bits set
- thrd_quiesced  in  THREADS  per-thread quiesce indication
- cfg_enter_dly  in  DLY_W  cycles between flush-disable and raising tholds; sampled on entry to FLUSHDIS
- cfg_exit_dly  in  DLY_W  cycles between lowering tholds and re-enabling flush; sampled on entry to LOWER
- rg_ck_fast_xstop  in  1  fast checkstop; blocks entry, forces wake
- lbist_en_dc  in  1  LBIST active; blocks entry, forces abort/wake
- ct_ck_pm_ccflush_disable  out  1  to clock control: suppress ccflush
- ct_ck_pm_raise_tholds  out  1  to clock control: raise run-domain tholds
- pm_sleep_active  out  1  core is in SLEEP
- pm_wake_done  out  1  one-cycle pulse when the wake sequence completes
- pm_state  out  3  encoded current state, for debug

## Operation
- There is one clock and one reset. Reset is synchronous and active-high.
- All outputs are decoded from registered state and registered count. No input reaches an output combinationally.
- States and their encodings:
  - RUN=0: all outputs 0.
  - QWAIT=1: all outputs 0.
  - FLUSHDIS=2: ccflush_disable=1.
  - SLEEP=3: ccflush_disable=1, raise_tholds=1, sleep_active=1.
  - LOWER=4: ccflush_disable=1.
  - FLUSHEN=5: wake_done=1, ccflush_disable=0.
  - Encodings 6 and 7 are illegal and go to RUN on the next cycle.
- Let `blk` = rg_ck_fast_xstop | lbist_en_dc.
- RUN -> QWAIT when &pm_sleep_req & ~blk.
- QWAIT:
  - Goes to RUN if ~&pm_sleep_req | blk. This takes priority.
  - Otherwise goes to FLUSHDIS when &thrd_quiesced, with cnt loaded from cfg_enter_dly.
  - Otherwise stays in QWAIT. The wait is unbounded.
- FLUSHDIS:
  - Goes to RUN if ~&pm_sleep_req | blk. This is an abort; raise_tholds was never asserted.
  - Otherwise, if cnt==0, goes to SLEEP.
  - Otherwise decrements cnt.
- SLEEP -> LOWER when ~&pm_sleep_req | blk, with cnt loaded from cfg_exit_dly.
- LOWER:
  - If cnt==0, goes to FLUSHEN. Otherwise decrements cnt.
  - LOWER cannot be aborted. Inputs are ignored.
- FLUSHEN -> RUN unconditionally.
- cnt is DLY_W bits. It only decrements in FLUSHDIS and LOWER, so it never wraps.
- Delay 0 is legal: the delay state lasts exactly 1 cycle.
- Reset at any point, including mid-sequence: state=RUN, cnt=0, all outputs 0 on the cycle after rst is sampled high. There is no partial wake handshake.
- Simultaneous events:
  - In QWAIT, a request drop and &thrd_quiesced in the same cycle: the abort wins.
  - In SLEEP, fast_xstop with requests still set: wake proceeds.
- Re-entry after a wake waits in RUN while blk=1 or until all requests are set again.

## Timing
- Requests all set and sampled at edge N: QWAIT visible at N+1.
- Quiesce sampled in QWAIT at edge M:
  - ccflush_disable rises at M+1.
  - raise_tholds rises at M+1+cfg_enter_dly+1.
- ccflush_disable always rises at least 1 cycle before raise_tholds.
- Wake trigger sampled in SLEEP at edge W:
  - raise_tholds falls at W+1.
  - ccflush_disable falls and wake_done pulses at W+1+cfg_exit_dly+1.
  - wake_done lasts exactly 1 cycle.
  - RUN is reached at W+cfg_exit_dly+3.
- ccflush_disable always falls at least 1 cycle after raise_tholds.
- Minimum full cycle with both delays 0, from entry-request sample to RUN: 6 cycles.

## Test plan
- Reset, then idle inputs:
  - pm_state=0 and all outputs 0.
  - Assert rst mid-SLEEP: all outputs 0 and state 0 on the next cycle.
- THREADS=2, cfg_enter_dly=3, req=2'b11 at cycle 0, quiesced=2'b11 at cycle 1:
  - ccflush_disable=1 from cycle 2.
  - raise_tholds=1 and sleep_active=1 from cycle 6.
- From SLEEP, cfg_exit_dly=2, drop req[1] at cycle 10:
  - raise_tholds=0 at cycle 11.
  - ccflush_disable=0 and wake_done=1 (single cycle) at cycle 14.
  - pm_state=0 at cycle 15.
- Abort:
  - In FLUSHDIS with cnt=5, assert lbist_en_dc: next cycle RUN, ccflush_disable=0, raise_tholds never asserted.
  - In QWAIT, drop a request on the same cycle quiesced completes: next cycle RUN.
- Fast checkstop:
  - rg_ck_fast_xstop=1 in SLEEP with req=2'b11: wake completes normally.
  - Hold xstop: stays in RUN.
  - Release xstop with req still 2'b11: QWAIT next cycle.
- cfg_enter_dly=0 and cfg_exit_dly=0:
  - ccflush_disable leads raise_tholds by exactly 1 cycle and trails its fall by exactly 1 cycle.
  - Changing the cfg values mid-delay does not alter the count already loaded.
